// File: rtl/sd_block_responder_if.sv
// Host-side block request bus of the SD block responder.
// The slave modport is the responder; the master modport is the requester.
interface sd_block_responder_if;
  logic          i_rd_en;
  logic          i_wr_en;
  logic [31:0]   i_addr;
  logic [4095:0] i_write_data;
  logic [4095:0] o_read_data;
  logic          o_busy;
  logic [15:0]   o_responder_state;

  modport slave (
    input  i_rd_en, i_wr_en, i_addr, i_write_data,
    output o_read_data, o_busy, o_responder_state
  );

  modport master (
    output i_rd_en, i_wr_en, i_addr, i_write_data,
    input  o_read_data, o_busy, o_responder_state
  );
endinterface

// File: rtl/sd_block_responder.sv
// RAM-backed stand-in for the SD controller block interface: answers rd_en/wr_en
// with the controller's busy handshake after a configurable number of wait cycles.
module sd_block_responder #(
  parameter int NUM_BLOCKS = 16,
  parameter int LATENCY    = 8
) (
  input logic               i_clock,
  input logic               i_reset,
  sd_block_responder_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int AW    = IDX_W + 7;

  typedef enum logic [15:0] {
    S_IDLE = 16'h0000,
    S_WAIT = 16'h0001,
    S_XFER = 16'h0002,
    S_DONE = 16'h0003
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_is_wr;
  logic [IDX_W-1:0] r_idx;
  logic [4095:0]    r_buf;
  logic [15:0]      r_wait;
  logic [6:0]       r_word;
  logic             r_busy;
  logic [4095:0]    r_read_data;
  logic [31:0]      r_mem [NUM_BLOCKS*128];
  logic [31:0]      r_ram_q;
  logic             w_accept;
  logic             w_ram_we;
  logic             w_shift_rd;
  logic [AW-1:0]    w_ram_addr;
  logic             w_unused_addr;

  assign w_unused_addr = ^bus.i_addr[31:IDX_W];

  // Next-state logic; unknown encodings fall back to Idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_wr_en || bus.i_rd_en) begin
          w_next = (LATENCY > 0) ? S_WAIT : S_XFER;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait == 16'(LATENCY - 1)) begin
          w_next = S_XFER;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_XFER: begin
        if (r_word == 7'd127) begin
          w_next = S_DONE;
        end else begin
          w_next = S_XFER;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = 1'b0;
    w_ram_we   = 1'b0;
    w_shift_rd = 1'b0;
    w_ram_addr = {r_idx, r_word};
    if (r_state == S_IDLE) begin
      w_accept = bus.i_wr_en || bus.i_rd_en;
    end else if (r_state == S_XFER) begin
      w_ram_we   = r_is_wr;
      // word 0 has no read data returned yet, so assembly starts one cycle late
      w_shift_rd = !r_is_wr && (r_word != 7'd0);
    end else begin
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_is_wr     <= 1'b0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_wait      <= 16'd0;
      r_word      <= 7'd0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_wait  <= (r_state == S_WAIT) ? (r_wait + 16'd1) : 16'd0;
      r_word  <= (r_state == S_XFER) ? (r_word + 7'd1) : 7'd0;
      if (w_accept) begin
        r_is_wr <= bus.i_wr_en;
        r_idx   <= bus.i_addr[IDX_W-1:0];
        r_buf   <= bus.i_wr_en ? bus.i_write_data : '0;
      end else if (w_ram_we) begin
        r_buf <= {32'h0000_0000, r_buf[4095:32]};
      end else if (w_shift_rd) begin
        r_buf <= {r_ram_q, r_buf[4095:32]};
      end else begin
        r_buf <= r_buf;
      end
      if (r_state == S_DONE && !r_is_wr) begin
        r_read_data <= {r_ram_q, r_buf[4095:32]};
      end else begin
        r_read_data <= r_read_data;
      end
    end
  end

  // Block storage is deliberately left out of reset.
  always_ff @(posedge i_clock) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= r_buf[31:0];
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  assign bus.o_busy            = r_busy;
  assign bus.o_read_data       = r_read_data;
  assign bus.o_responder_state = r_state;
endmodule

// File: tb/tb_sd_block_responder.sv
// Directed self-checking bench for sd_block_responder: a vector table on a
// LATENCY=8 instance plus hand-written sequences, with LATENCY=0/3 instances.
module tb_sd_block_responder;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic [4095:0] wdata = '0;
  int            sel = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  sd_block_responder_if if8 ();
  sd_block_responder_if if0 ();
  sd_block_responder_if if3 ();

  assign if8.i_rd_en = rd_en & (sel == 0);
  assign if8.i_wr_en = wr_en & (sel == 0);
  assign if0.i_rd_en = rd_en & (sel == 1);
  assign if0.i_wr_en = wr_en & (sel == 1);
  assign if3.i_rd_en = rd_en & (sel == 2);
  assign if3.i_wr_en = wr_en & (sel == 2);
  assign if8.i_addr = addr;
  assign if0.i_addr = addr;
  assign if3.i_addr = addr;
  assign if8.i_write_data = wdata;
  assign if0.i_write_data = wdata;
  assign if3.i_write_data = wdata;

  sd_block_responder #(.NUM_BLOCKS(16), .LATENCY(8)) u_dut8 (.i_clock(clk), .i_reset(rst), .bus(if8));
  sd_block_responder #(.NUM_BLOCKS(16), .LATENCY(0)) u_dut0 (.i_clock(clk), .i_reset(rst), .bus(if0));
  sd_block_responder #(.NUM_BLOCKS(16), .LATENCY(3)) u_dut3 (.i_clock(clk), .i_reset(rst), .bus(if3));

  logic          busy_s;
  logic [4095:0] rdata_s;
  logic [15:0]   state_s;

  always_comb begin
    case (sel)
      1: begin busy_s = if0.o_busy; rdata_s = if0.o_read_data; state_s = if0.o_responder_state; end
      2: begin busy_s = if3.o_busy; rdata_s = if3.o_read_data; state_s = if3.o_responder_state; end
      default: begin busy_s = if8.o_busy; rdata_s = if8.o_read_data; state_s = if8.o_responder_state; end
    endcase
  end

  function automatic logic [4095:0] pat(input int id);
    logic [4095:0] v;
    logic [31:0]   w;
    for (int k = 0; k < 128; k++) begin
      case (id)
        1: w = 32'hA500_0000 + 32'(k);
        2: w = 32'hFFFF_FFFF;
        3: w = 32'h3C3C_0000 + 32'(k * 7);
        4: w = 32'h1234_0000 ^ (32'(k) << 8);
        5: w = 32'hC0DE_0000 + 32'(k);
        6: w = (k < 40) ? 32'h0000_0000 : 32'hFFFF_FFFF;
        default: w = 32'h0000_0000;
      endcase
      v[32*k +: 32] = w;
    end
    return v;
  endfunction

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [4095:0] act, input logic [4095:0] exp);
    int bad_word;
    checks++;
    if (act !== exp) begin
      errors++;
      bad_word = -1;
      for (int k = 127; k >= 0; k--) begin
        if (act[32*k +: 32] !== exp[32*k +: 32]) bad_word = k;
      end
      $display("FAIL %s: word %0d got %h expected %h", name, bad_word,
               act[32*bad_word +: 32], exp[32*bad_word +: 32]);
    end
  endtask

  // Issue one request from Idle and count the cycles busy stays high.
  task automatic do_op(input bit w, input bit r, input logic [31:0] a,
                       input logic [4095:0] d, output int n);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; wdata = '1; addr = 32'hFFFF_FFFF;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy_s) break;
      n++;
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    int          dpat;
    int          exp_busy;
    int          exp_rpat;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    int bad;
    int starts;
    int idle_run;
    int exp_next;
    bit seen_busy;
    logic [15:0] st;
    logic [15:0] prev;

    vt[0] = '{wr: 1'b0, rd: 1'b1, a: 32'd4,    dpat: 0, exp_busy: 137, exp_rpat: 0};
    vt[1] = '{wr: 1'b1, rd: 1'b0, a: 32'd8192, dpat: 1, exp_busy: 137, exp_rpat: 0};
    vt[2] = '{wr: 1'b0, rd: 1'b1, a: 32'd8192, dpat: 0, exp_busy: 137, exp_rpat: 1};
    vt[3] = '{wr: 1'b1, rd: 1'b0, a: 32'd1,    dpat: 2, exp_busy: 137, exp_rpat: 1};
    vt[4] = '{wr: 1'b1, rd: 1'b0, a: 32'd6,    dpat: 3, exp_busy: 137, exp_rpat: 1};
    vt[5] = '{wr: 1'b0, rd: 1'b1, a: 32'd22,   dpat: 0, exp_busy: 137, exp_rpat: 3};
    vt[6] = '{wr: 1'b1, rd: 1'b1, a: 32'd2,    dpat: 4, exp_busy: 137, exp_rpat: 3};
    vt[7] = '{wr: 1'b0, rd: 1'b1, a: 32'd2,    dpat: 0, exp_busy: 137, exp_rpat: 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("reset_busy", busy_s, 0);
    chk_int("reset_state", state_s, 0);
    chk_blk("reset_rdata", rdata_s, pat(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].wr, vt[i].rd, vt[i].a, pat(vt[i].dpat), n);
      chk_int($sformatf("vec%0d_busy", i), n, vt[i].exp_busy);
      chk_blk($sformatf("vec%0d_rdata", i), rdata_s, pat(vt[i].exp_rpat));
    end

    // A read pulse in the middle of a write must be dropped, not queued.
    @(negedge clk);
    wr_en = 1'b1; addr = 32'd3; wdata = pat(5);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 20) begin rd_en = 1'b1; addr = 32'd5; end
      if (i == 21) rd_en = 1'b0;
      if (!busy_s) break;
      n++;
    end
    chk_int("ignore_write_busy", n, 137);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_s) bad++;
    end
    chk_int("ignore_no_queue", bad, 0);
    chk_blk("ignore_rdata_kept", rdata_s, pat(4));
    do_op(1'b0, 1'b1, 32'd19, '0, n);
    chk_int("alias_busy", n, 137);
    chk_blk("alias_rdata", rdata_s, pat(5));

    sel = 1;
    do_op(1'b1, 1'b0, 32'd9, pat(1), n);
    chk_int("lat0_write_busy", n, 129);
    do_op(1'b0, 1'b1, 32'd25, '0, n);
    chk_int("lat0_read_busy", n, 129);
    chk_blk("lat0_rdata", rdata_s, pat(1));
    sel = 2;
    do_op(1'b0, 1'b1, 32'd7, '0, n);
    chk_int("lat3_read_busy", n, 132);
    chk_blk("lat3_rdata", rdata_s, pat(0));
    sel = 0;

    // Reset while word 40 of an all-zero write to block 1 is in flight.
    @(negedge clk);
    wr_en = 1'b1; addr = 32'd1; wdata = pat(0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    chk_int("pre_reset_state", state_s, 2);
    rst = 1'b1;
    #1;
    chk_int("midreset_busy", busy_s, 0);
    chk_int("midreset_state", state_s, 0);
    chk_blk("midreset_rdata", rdata_s, pat(0));
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 1'b1, 32'd1, '0, n);
    chk_int("partial_busy", n, 137);
    chk_blk("partial_rdata", rdata_s, pat(6));

    // Held rd_en: back-to-back reads with exactly one Idle cycle between them.
    @(negedge clk);
    rd_en = 1'b1; addr = 32'd2;
    bad = 0; starts = 0; idle_run = 1; seen_busy = 1'b0; prev = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      st = state_s;
      if (busy_s != (st != 16'h0000)) bad++;
      if (st != prev) begin
        exp_next = (prev == 16'h0003) ? 0 : int'(prev) + 1;
        if (int'(st) != exp_next) bad++;
        if (prev == 16'h0000 && seen_busy && idle_run != 1) bad++;
        if (st == 16'h0001) starts++;
        if (prev == 16'h0003) seen_busy = 1'b1;
      end
      if (st == 16'h0000) idle_run = (prev == 16'h0000) ? idle_run + 1 : 1;
      else idle_run = 0;
      prev = st;
    end
    rd_en = 1'b0;
    chk_int("held_sequence_errors", bad, 0);
    chk_int("held_starts", starts, 3);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_s) break;
      @(negedge clk);
      n++;
    end
    chk_int("held_final_state", state_s, 0);
    chk_blk("held_rdata", rdata_s, pat(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
